// File: rtl/mem_wb_pipe_pkg.sv
// Shared core definitions for the MEM->WB boundary.
// Beat struct is sized for the widest supported configuration.
package mem_wb_pipe_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_LANES  = 4;

    localparam logic [MAX_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic [MAX_DATA_W-1:0] ZERO_WORD     = '0;
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;

    typedef struct packed {
        logic [MAX_LANES-1:0][MAX_ADDR_W-1:0] wd;
        logic [MAX_LANES-1:0]                 wreg;
        logic [MAX_LANES-1:0][MAX_DATA_W-1:0] wdata;
        logic                                 whilo;
        logic [MAX_DATA_W-1:0]                hi;
        logic [MAX_DATA_W-1:0]                lo;
    } wb_beat_t;

    function automatic wb_beat_t nop_beat();
        wb_beat_t b;
        for (int i = 0; i < MAX_LANES; i++) begin
            b.wd[i]    = NOP_REG_ADDR;
            b.wreg[i]  = WRITE_DISABLE;
            b.wdata[i] = ZERO_WORD;
        end
        b.whilo = WRITE_DISABLE;
        b.hi    = ZERO_WORD;
        b.lo    = ZERO_WORD;
        return b;
    endfunction

endpackage

// File: rtl/mem_wb_entry.sv
// One valid+payload slot of the MEM/WB buffer.
// Clear returns the payload to a NOP so an empty slot never carries a write.
module mem_wb_entry
    import mem_wb_pipe_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    input  logic     load,
    input  wb_beat_t d,
    output logic     valid,
    output wb_beat_t q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= 1'b0;
            q     <= nop_beat();
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with a one-deep skid buffer.
// mem_ready depends only on registered state, never on wb_ready.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [LANES*ADDR_W-1:0] mem_wd,
    input  logic [LANES-1:0]        mem_wreg,
    input  logic [LANES*DATA_W-1:0] mem_wdata,
    input  logic                    mem_whilo,
    input  logic [DATA_W-1:0]       mem_hi,
    input  logic [DATA_W-1:0]       mem_lo,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [LANES*ADDR_W-1:0] wb_wd,
    output logic [LANES-1:0]        wb_wreg,
    output logic [LANES*DATA_W-1:0] wb_wdata,
    output logic                    wb_whilo,
    output logic [DATA_W-1:0]       wb_hi,
    output logic [DATA_W-1:0]       wb_lo,
    output logic [1:0]              occupancy
);

    wb_beat_t in_beat;
    wb_beat_t main_q;
    wb_beat_t skid_q;
    wb_beat_t main_d;
    wb_beat_t out_beat;
    logic     main_v;
    logic     skid_v;
    logic     acc;
    logic     con;
    logic     main_load;
    logic     main_clr;
    logic     skid_load;
    logic     skid_clr;
    logic     unused_beat_bits;

    always_comb begin
        in_beat = nop_beat();
        for (int i = 0; i < LANES; i++) begin
            in_beat.wd[i][ADDR_W-1:0] =
                mem_wd[i*ADDR_W +: ADDR_W];
            in_beat.wreg[i] = mem_wreg[i];
            in_beat.wdata[i][DATA_W-1:0] =
                mem_wdata[i*DATA_W +: DATA_W];
        end
        in_beat.whilo           = mem_whilo;
        in_beat.hi[DATA_W-1:0]  = mem_hi;
        in_beat.lo[DATA_W-1:0]  = mem_lo;
    end

    assign mem_ready = ~skid_v;
    assign acc       = mem_valid & mem_ready;
    assign con       = main_v & wb_ready;

    // A skid beat always takes precedence over the input when main drains.
    assign main_d    = skid_v ? skid_q : in_beat;
    assign main_load = ~flush &
                       (con ? (skid_v | acc) : (~main_v & acc));
    assign main_clr  = flush | (con & ~skid_v & ~acc);
    assign skid_load = ~flush & acc & main_v & ~con;
    assign skid_clr  = flush | (con & skid_v);

    mem_wb_entry u_main (
        .clk   (clk),
        .rst   (rst),
        .clr   (main_clr),
        .load  (main_load),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    mem_wb_entry u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr   (skid_clr),
        .load  (skid_load),
        .d     (in_beat),
        .valid (skid_v),
        .q     (skid_q)
    );

    always_comb begin
        out_beat = main_v ? main_q : nop_beat();
        wb_wd    = '0;
        wb_wreg  = '0;
        wb_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            wb_wd[i*ADDR_W +: ADDR_W] =
                out_beat.wd[i][ADDR_W-1:0];
            wb_wreg[i] = out_beat.wreg[i];
            wb_wdata[i*DATA_W +: DATA_W] =
                out_beat.wdata[i][DATA_W-1:0];
        end
        wb_whilo = out_beat.whilo;
        wb_hi    = out_beat.hi[DATA_W-1:0];
        wb_lo    = out_beat.lo[DATA_W-1:0];
    end

    assign unused_beat_bits = ^out_beat;
    assign wb_valid  = main_v;
    assign occupancy = {main_v & skid_v, main_v ^ skid_v};

endmodule
